// File: rtl/saes32_round_seq_pkg.sv
`default_nettype none
// ============================================================================
// saes32_round_seq_pkg : FSM encodings and decode helpers for the round sequencer
// Revision: 1.0
// ============================================================================
package saes32_round_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic encs;
        logic encsm;
        logic decs;
        logic decsm;
    } fu_op_t;

    function automatic fu_op_t op_decode(input logic dec, input logic mix);
        fu_op_t op;
        op.encs  = ~dec & ~mix;
        op.encsm = ~dec &  mix;
        op.decs  =  dec & ~mix;
        op.decsm =  dec &  mix;
        return op;
    endfunction

    // 2-bit wrap of col +/- bs realises ShiftRows / InvShiftRows
    function automatic logic [1:0] sel_col(input logic dec, input logic [1:0] col,
                                           input logic [1:0] bs);
        logic [1:0] k;
        k = dec ? (col - bs) : (col + bs);
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/saes32_round_seq.sv
`default_nettype none
// ============================================================================
// saes32_round_seq : sequences one AES round as 16 saes32 ops on an attached FU
// Revision: 1.0
// ============================================================================
module saes32_round_seq
    import saes32_round_seq_pkg::*;
#(
    parameter int GATE_IDLE = 1
) (
    input  logic         g_clk,
    input  logic         g_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_dec,
    input  logic         in_mix,
    input  logic [127:0] in_state,
    input  logic [127:0] in_rkey,
    output logic         fu_valid,
    output logic         fu_op_encs,
    output logic         fu_op_encsm,
    output logic         fu_op_decs,
    output logic         fu_op_decsm,
    output logic [31:0]  fu_rs1,
    output logic [31:0]  fu_rs2,
    output logic [1:0]   fu_bs,
    input  logic [31:0]  fu_rd,
    input  logic         fu_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    seq_state_t   r_state;
    seq_state_t   w_state_nxt;
    logic         r_dec;
    logic         r_mix;
    logic [127:0] r_st;
    logic [127:0] r_rkey;
    logic [127:0] r_out;
    logic [1:0]   r_col;
    logic [1:0]   r_bs;
    logic [31:0]  r_acc;

    logic         w_run;
    logic         w_accept;
    logic         w_fire;
    logic         w_last;
    logic [1:0]   w_k;
    logic [1:0]   w_col_nxt;
    logic [31:0]  w_rs2;
    logic [31:0]  w_rkey_nxt;
    fu_op_t       w_op;

    assign w_run      = (r_state == ST_RUN);
    assign w_accept   = in_valid & (r_state == ST_IDLE);
    assign w_fire     = w_run & fu_ready;
    assign w_last     = w_fire & (r_bs == 2'd3) & (r_col == 2'd3);
    assign w_k        = sel_col(r_dec, r_col, r_bs);
    assign w_col_nxt  = r_col + 2'd1;
    assign w_rs2      = r_st[{w_k, 5'd0} +: 32];
    assign w_rkey_nxt = r_rkey[{w_col_nxt, 5'd0} +: 32];
    assign w_op       = op_decode(r_dec, r_mix);

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // fu_rd is only ever captured on a completed FU handshake
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            r_dec  <= 1'b0;
            r_mix  <= 1'b0;
            r_st   <= '0;
            r_rkey <= '0;
            r_out  <= '0;
            r_col  <= 2'd0;
            r_bs   <= 2'd0;
            r_acc  <= '0;
        end else if (w_accept) begin
            r_dec  <= in_dec;
            r_mix  <= in_mix;
            r_st   <= in_state;
            r_rkey <= in_rkey;
            r_col  <= 2'd0;
            r_bs   <= 2'd0;
            r_acc  <= in_rkey[31:0];
        end else if (w_fire) begin
            if (r_bs == 2'd3) begin
                r_out[{r_col, 5'd0} +: 32] <= fu_rd;
                r_col <= w_col_nxt;
                r_bs  <= 2'd0;
                r_acc <= w_rkey_nxt;
            end else begin
                r_bs  <= r_bs + 2'd1;
                r_acc <= fu_rd;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_state = r_out;
    assign fu_valid  = w_run;

    generate
        if (GATE_IDLE != 0) begin : g_gate_idle
            assign fu_rs1      = w_run ? r_acc : 32'd0;
            assign fu_rs2      = w_run ? w_rs2 : 32'd0;
            assign fu_bs       = w_run ? r_bs  : 2'd0;
            assign fu_op_encs  = w_run & w_op.encs;
            assign fu_op_encsm = w_run & w_op.encsm;
            assign fu_op_decs  = w_run & w_op.decs;
            assign fu_op_decsm = w_run & w_op.decsm;
        end else begin : g_no_gate
            assign fu_rs1      = r_acc;
            assign fu_rs2      = w_rs2;
            assign fu_bs       = r_bs;
            assign fu_op_encs  = w_op.encs;
            assign fu_op_encsm = w_op.encsm;
            assign fu_op_decs  = w_op.decs;
            assign fu_op_decsm = w_op.decsm;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_saes32_round_seq.sv
`default_nettype none
// Bench for saes32_round_seq: FIPS-197 round vectors through a behavioural saes32 FU,
// plus stall, reset-abort and back-to-back sequences.
module tb_saes32_round_seq;

    logic         g_clk = 1'b0;
    logic         g_rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_dec = 1'b0;
    logic         in_mix = 1'b0;
    logic [127:0] in_state = '0;
    logic [127:0] in_rkey = '0;
    logic         fu_valid;
    logic         fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm;
    logic [31:0]  fu_rs1, fu_rs2;
    logic [1:0]   fu_bs;
    logic [31:0]  fu_rd;
    logic         fu_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         stall = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 g_clk = ~g_clk;

    saes32_round_seq #(.GATE_IDLE(1)) dut (
        .g_clk(g_clk), .g_rst(g_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec), .in_mix(in_mix),
        .in_state(in_state), .in_rkey(in_rkey),
        .fu_valid(fu_valid), .fu_op_encs(fu_op_encs), .fu_op_encsm(fu_op_encsm),
        .fu_op_decs(fu_op_decs), .fu_op_decsm(fu_op_decsm),
        .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_bs(fu_bs),
        .fu_rd(fu_rd), .fu_ready(fu_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
    );

    // ---------------- behavioural saes32 FU ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] c;
        if (a == 8'h00) return 8'h00;
        for (int i = 1; i < 256; i++) begin
            c = i[7:0];
            if (gmul(a, c) == 8'h01) return c;
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        logic [7:0] r;
        v = ginv(x);
        for (int i = 0; i < 8; i++)
            r[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8];
        return r ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        for (int i = 0; i < 8; i++)
            b[i] = y[(i+2)%8] ^ y[(i+5)%8] ^ y[(i+7)%8];
        return ginv(b ^ 8'h05);
    endfunction

    function automatic logic [31:0] fu_model(input logic [3:0] op, input logic [31:0] rs1,
                                             input logic [31:0] rs2, input logic [1:0] bs);
        logic [7:0]  si, so;
        logic [31:0] m, r;
        si = rs2[8*bs +: 8];
        so = (op[3] | op[2]) ? sbox(si) : inv_sbox(si);
        if (op[2])      m = {gmul(so, 8'h03), so, so, gmul(so, 8'h02)};
        else if (op[0]) m = {gmul(so, 8'h0b), gmul(so, 8'h0d), gmul(so, 8'h09), gmul(so, 8'h0e)};
        else            m = {24'd0, so};
        case (bs)
            2'd0:    r = m;
            2'd1:    r = {m[23:0], m[31:24]};
            2'd2:    r = {m[15:0], m[31:16]};
            default: r = {m[7:0],  m[31:8]};
        endcase
        return rs1 ^ r;
    endfunction

    // Garbage on fu_rd while not ready: it must never be captured.
    always_comb begin
        fu_ready = fu_valid & ~stall;
        fu_rd    = 32'hdeadbeef;
        if (fu_ready)
            fu_rd = fu_model({fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm},
                             fu_rs1, fu_rs2, fu_bs);
    end

    // ---------------- helpers ----------------
    // FIPS byte string (first byte leftmost) -> port packing (byte k at [8k+7:8k])
    function automatic logic [127:0] bsw(input logic [127:0] h);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = h[127-8*k -: 8];
        return r;
    endfunction

    function automatic logic [127:0] sr_sb(input logic [127:0] p);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++)
                r[32*c + 8*i +: 8] = sbox(p[32*((c+i)%4) + 8*i +: 8]);
        return r;
    endfunction

    function automatic logic [69:0] fu_snap();
        return {fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm, fu_rs1, fu_rs2, fu_bs};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    typedef struct {
        logic         dec;
        logic         mix;
        logic [127:0] st;
        logic [127:0] rk;
        logic [127:0] res;
        int           stall_at;
        int           stall_len;
        int           ordly;
    } vec_t;

    vec_t vt [5];

    task automatic run_round(input vec_t v, input int idx);
        int          cyc, ops, stall_left, bad_rdy, bad_op, bad_stall, bad_hold;
        logic [69:0] snap;
        logic [127:0] held;
        logic [3:0]  exp_op;
        exp_op = {~v.dec & ~v.mix, ~v.dec & v.mix, v.dec & ~v.mix, v.dec & v.mix};
        ops = 0; stall_left = v.stall_len;
        bad_rdy = 0; bad_op = 0; bad_stall = 0; bad_hold = 0; snap = '0;
        @(negedge g_clk);
        check($sformatf("v%0d_idle_ready", idx), in_ready, 1);
        in_valid = 1'b1; in_dec = v.dec; in_mix = v.mix; in_state = v.st; in_rkey = v.rk;
        @(negedge g_clk);
        in_valid = 1'b0; in_dec = ~v.dec; in_mix = ~v.mix;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_rkey  = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            if (in_ready) bad_rdy++;
            if (!fu_valid) bad_op++;
            else begin
                if ({fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm} != exp_op) bad_op++;
                if (ops == v.stall_at && stall_left > 0) begin
                    if (stall_left < v.stall_len && fu_snap() != snap) bad_stall++;
                    snap = fu_snap();
                    stall = 1'b1;
                    stall_left--;
                end else begin
                    if (v.stall_len > 0 && ops == v.stall_at && fu_snap() != snap) bad_stall++;
                    stall = 1'b0;
                    ops++;
                end
            end
            @(negedge g_clk);
            cyc++;
        end
        stall = 1'b0;
        check($sformatf("v%0d_latency", idx), cyc, 17 + v.stall_len);
        check($sformatf("v%0d_result", idx), out_state, v.res);
        check($sformatf("v%0d_done_fu_idle", idx),
              {fu_valid, fu_snap()}, '0);
        if (in_ready) bad_rdy++;
        held = out_state;
        for (int k = 0; k < v.ordly; k++) begin
            @(negedge g_clk);
            if (!out_valid || out_state !== held || in_ready || fu_valid) bad_hold++;
        end
        out_ready = 1'b1;
        @(negedge g_clk);
        out_ready = 1'b0;
        check($sformatf("v%0d_busy_ready", idx), bad_rdy, 0);
        check($sformatf("v%0d_opcode", idx), bad_op, 0);
        if (v.stall_len > 0) check($sformatf("v%0d_stall_stable", idx), bad_stall, 0);
        if (v.ordly > 0)     check($sformatf("v%0d_out_hold", idx), bad_hold, 0);
        check($sformatf("v%0d_after_hs", idx), {out_valid, in_ready, fu_valid}, 3'b010);
    endtask

    task automatic wait_out_valid(input string name);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(negedge g_clk);
            cnt++;
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: out_valid timeout, got 0, expected 1", name);
        end
    endtask

    initial begin
        int ops, cnt;
        logic [127:0] fin_out, fin_rk;

        fin_out = bsw(128'h3925841d02dc09fbdc118597196a0b32);
        fin_rk  = bsw(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        vt[0] = '{1'b0, 1'b1, bsw(128'h193de3bea0f4e22b9ac68d2ae9f84808),
                  bsw(128'ha0fafe1788542cb123a339392a6c7605),
                  bsw(128'ha49c7ff2689f352b6b5bea43026a5049), -1, 0, 0};
        vt[1] = '{1'b0, 1'b0, bsw(128'heb40f21e592e38848ba113e71bc342d2),
                  fin_rk, fin_out, -1, 0, 0};
        vt[2] = '{1'b1, 1'b0, fin_out ^ fin_rk, '0,
                  bsw(128'heb40f21e592e38848ba113e71bc342d2), -1, 0, 1};
        vt[3] = vt[0];
        vt[3].stall_at = 5; vt[3].stall_len = 3; vt[3].ordly = 4;
        // InvMixColumns(InvSubBytes(InvShiftRows(SR(SB(x))))) = InvMixColumns(x); with x = MixColumns output
        vt[4] = '{1'b1, 1'b1, sr_sb(bsw(128'h046681e5e0cb199a48f8d37a2806264c)), '0,
                  bsw(128'hd4bf5d30e0b452aeb84111f11e2798e5), -1, 0, 2};

        // reset state
        g_rst = 1'b1;
        repeat (2) @(negedge g_clk);
        check("reset_flags", {in_ready, fu_valid, out_valid}, 3'b100);
        check("reset_out_state", out_state, '0);
        check("reset_fu_gated", fu_snap(), '0);
        check("col0_word", vt[0].res[31:0], 32'hf27f9ca4);
        g_rst = 1'b0;

        for (int i = 0; i < 5; i++) run_round(vt[i], i);

        // reset while op 9 is on the FU
        @(negedge g_clk);
        in_valid = 1'b1; in_dec = vt[0].dec; in_mix = vt[0].mix;
        in_state = vt[0].st; in_rkey = vt[0].rk;
        @(negedge g_clk);
        in_valid = 1'b0;
        ops = 0; cnt = 0;
        while (ops < 9 && cnt < 50) begin
            if (fu_valid) ops++;
            @(negedge g_clk);
            cnt++;
        end
        check("rst_reach_op9", ops, 9);
        g_rst = 1'b1;
        @(negedge g_clk);
        g_rst = 1'b0;
        check("rst_mid_flags", {in_ready, fu_valid, out_valid}, 3'b100);
        check("rst_mid_out_state", out_state, '0);
        run_round(vt[1], 5);

        // back-to-back with in_valid held high
        @(negedge g_clk);
        in_valid = 1'b1; in_dec = vt[0].dec; in_mix = vt[0].mix;
        in_state = vt[0].st; in_rkey = vt[0].rk;
        @(negedge g_clk);
        in_dec = vt[1].dec; in_mix = vt[1].mix; in_state = vt[1].st; in_rkey = vt[1].rk;
        wait_out_valid("b2b_first_wait");
        check("b2b_first_result", out_state, vt[0].res);
        out_ready = 1'b1;
        @(negedge g_clk);
        out_ready = 1'b0;
        check("b2b_idle_gap", {out_valid, in_ready, fu_valid}, 3'b010);
        @(negedge g_clk);
        in_valid = 1'b0;
        check("b2b_second_accept", {in_ready, fu_valid}, 2'b01);
        wait_out_valid("b2b_second_wait");
        check("b2b_second_result", out_state, vt[1].res);
        out_ready = 1'b1;
        @(negedge g_clk);
        out_ready = 1'b0;
        check("b2b_final_idle", {out_valid, in_ready}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
